// File: rtl/prefetcher_pkg.sv
// Shared prefetcher definitions: queue entry lifecycle, default address geometry
// and the block-tag helper used by both the controller and the block queue.
package prefetcher_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ALLOC  = 2'd1,
        ISSUED = 2'd2,
        READY  = 2'd3
    } entry_state_e;

    localparam int DEFAULT_ADDR_BITS         = 64;
    localparam int DEFAULT_BLOCK_OFFSET_BITS = 6;
    localparam int MAX_ADDR_BITS             = 128;

    // Callers narrow the result to their own tag width.
    function automatic logic [MAX_ADDR_BITS-1:0] block_tag(
        input logic [MAX_ADDR_BITS-1:0] addr,
        input int                       offset_bits
    );
        return addr >> offset_bits;
    endfunction

endpackage

// File: rtl/prefetch_issue_reg.sv
// Valid/ready holding register for memory read requests; once valid, the
// request address stays stable until the memory side accepts it.
module prefetch_issue_reg #(
    parameter int ADDR_BITS = 64,
    parameter int IDX_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [IDX_BITS-1:0]  load_idx,
    input  logic                 unlink,
    input  logic                 ready,
    output logic                 can_load,
    output logic                 accepted,
    output logic                 valid,
    output logic [ADDR_BITS-1:0] addr,
    output logic [IDX_BITS-1:0]  idx,
    output logic                 linked
);

    assign can_load = !valid || ready;
    assign accepted = valid && ready;

    // An unlinked request still goes to memory, but no queue entry owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            addr   <= '0;
            idx    <= '0;
            linked <= 1'b0;
        end else if (can_load) begin
            valid  <= load_valid;
            linked <= load_valid && !unlink;
            if (load_valid) begin
                addr <= load_addr;
                idx  <= load_idx;
            end
        end else if (unlink) begin
            linked <= 1'b0;
        end
    end

endmodule

// File: rtl/prefetch_block_queue.sv
// Consumer side of the prefetcher: in-order circular queue of prefetched blocks
// with memory issue, response fill, head-only demand lookup, timeout and flush draining.
module prefetch_block_queue
    import prefetcher_pkg::*;
#(
    parameter int ADDR_BITS          = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS          = 512,
    parameter int BLOCK_OFFSET_BITS  = DEFAULT_BLOCK_OFFSET_BITS,
    parameter int QUEUE_DEPTH        = 16,
    parameter int ALMOST_FULL_MARGIN = 2,
    parameter int TIMEOUT_CYCLES     = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             prefetchedAddrValid,
    input  logic [ADDR_BITS-1:0]             prefetchedAddr,
    input  logic                             flushN,
    input  logic                             inAddrReqValid,
    input  logic [ADDR_BITS-1:0]             inAddrReq,
    output logic                             addrReqHit,
    output logic                             addrReqPending,
    output logic                             hitDataValid,
    output logic [DATA_BITS-1:0]             hitData,
    output logic                             prefetchDrop,
    output logic                             memReqValid,
    output logic [ADDR_BITS-1:0]             memReqAddr,
    input  logic                             memReqReady,
    input  logic                             memRspValid,
    input  logic [DATA_BITS-1:0]             memRspData,
    output logic                             almostFull,
    output logic [$clog2(QUEUE_DEPTH)+1:0]   outstandingReqCnt
);

    localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
    localparam int OCC_BITS = PTR_BITS + 1;
    localparam int OUT_BITS = PTR_BITS + 2;
    localparam int TAG_BITS = ADDR_BITS - BLOCK_OFFSET_BITS;
    localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES) + 1;

    entry_state_e         entry_state [QUEUE_DEPTH];
    logic [TAG_BITS-1:0]  entry_tag   [QUEUE_DEPTH];
    logic [DATA_BITS-1:0] entry_data  [QUEUE_DEPTH];

    logic [PTR_BITS-1:0]  tail_ptr, issue_ptr, fill_ptr, head_ptr;
    logic [OCC_BITS-1:0]  occupancy, occupancy_next;
    logic [OUT_BITS-1:0]  drain_cnt, drain_next, outstanding_next;
    logic [TMO_BITS-1:0]  timeout_cnt;

    logic full, do_alloc, head_match, head_ready, timed_out, do_pop;
    logic rsp_drain, rsp_fill, load_valid, do_load;
    logic issue_can_load, issue_accepted, issue_valid, issue_linked;
    logic [PTR_BITS-1:0]  issue_idx;
    logic [ADDR_BITS-1:0] issue_addr;

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [ADDR_BITS-1:0] addr);
        return TAG_BITS'(block_tag(MAX_ADDR_BITS'(addr), BLOCK_OFFSET_BITS));
    endfunction

    assign full       = (occupancy == OCC_BITS'(QUEUE_DEPTH));
    assign do_alloc   = prefetchedAddrValid && !full && flushN;
    assign head_match = inAddrReqValid && (tag_of(inAddrReq) == entry_tag[head_ptr]);
    assign head_ready = (entry_state[head_ptr] == READY);

    assign addrReqHit     = head_match && head_ready;
    assign addrReqPending = head_match &&
                            ((entry_state[head_ptr] == ALLOC) || (entry_state[head_ptr] == ISSUED));

    assign timed_out = head_ready && (timeout_cnt == TMO_BITS'(TIMEOUT_CYCLES - 1));
    assign do_pop    = flushN && (addrReqHit || timed_out);

    // Responses owed to flushed requests are consumed before any fill.
    assign rsp_drain = memRspValid && (drain_cnt != '0);
    assign rsp_fill  = memRspValid && (drain_cnt == '0) && flushN;

    assign load_valid = flushN && (entry_state[issue_ptr] == ALLOC);
    assign do_load    = issue_can_load && load_valid;

    prefetch_issue_reg #(
        .ADDR_BITS (ADDR_BITS),
        .IDX_BITS  (PTR_BITS)
    ) u_issue_reg (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_addr  ({entry_tag[issue_ptr], {BLOCK_OFFSET_BITS{1'b0}}}),
        .load_idx   (issue_ptr),
        .unlink     (!flushN),
        .ready      (memReqReady),
        .can_load   (issue_can_load),
        .accepted   (issue_accepted),
        .valid      (issue_valid),
        .addr       (issue_addr),
        .idx        (issue_idx),
        .linked     (issue_linked)
    );

    assign memReqValid = issue_valid;
    assign memReqAddr  = issue_addr;

    always_comb begin
        outstanding_next = outstandingReqCnt;
        if (issue_accepted) outstanding_next = outstanding_next + OUT_BITS'(1);
        if (memRspValid)    outstanding_next = outstanding_next - OUT_BITS'(1);
    end

    // On flush every request still owed by memory, plus the one waiting in the
    // holding register, becomes a response to throw away.
    always_comb begin
        drain_next = drain_cnt;
        if (!flushN) begin
            drain_next = outstandingReqCnt - OUT_BITS'(memRspValid) + OUT_BITS'(issue_valid);
        end else if (rsp_drain) begin
            drain_next = drain_cnt - OUT_BITS'(1);
        end
    end

    always_comb begin
        occupancy_next = occupancy;
        if (!flushN) begin
            occupancy_next = '0;
        end else begin
            if (do_alloc) occupancy_next = occupancy_next + OCC_BITS'(1);
            if (do_pop)   occupancy_next = occupancy_next - OCC_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) entry_state[i] <= EMPTY;
            tail_ptr  <= '0;
            issue_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
        end else if (!flushN) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) entry_state[i] <= EMPTY;
            tail_ptr  <= '0;
            issue_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
        end else begin
            if (do_alloc) begin
                entry_state[tail_ptr] <= ALLOC;
                tail_ptr <= tail_ptr + PTR_BITS'(1);
            end
            if (issue_accepted && issue_linked) begin
                entry_state[issue_idx] <= ISSUED;
            end
            if (rsp_fill) begin
                entry_state[fill_ptr] <= READY;
                fill_ptr <= fill_ptr + PTR_BITS'(1);
            end
            if (do_pop) begin
                entry_state[head_ptr] <= EMPTY;
                head_ptr <= head_ptr + PTR_BITS'(1);
            end
            if (do_load) begin
                issue_ptr <= issue_ptr + PTR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) entry_tag[tail_ptr] <= tag_of(prefetchedAddr);
        if (rsp_fill) entry_data[fill_ptr] <= memRspData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupancy         <= '0;
            drain_cnt         <= '0;
            outstandingReqCnt <= '0;
            almostFull        <= 1'b0;
            prefetchDrop      <= 1'b0;
            hitDataValid      <= 1'b0;
            hitData           <= '0;
            timeout_cnt       <= '0;
        end else begin
            occupancy         <= occupancy_next;
            drain_cnt         <= drain_next;
            outstandingReqCnt <= outstanding_next;
            almostFull        <= (occupancy_next >= OCC_BITS'(QUEUE_DEPTH - ALMOST_FULL_MARGIN));
            prefetchDrop      <= prefetchedAddrValid && (full || !flushN);
            hitDataValid      <= addrReqHit;
            if (addrReqHit) hitData <= entry_data[head_ptr];
            // Age restarts whenever the head is consumed, replaced or not yet filled.
            if (!flushN || do_pop || !head_ready) begin
                timeout_cnt <= '0;
            end else begin
                timeout_cnt <= timeout_cnt + TMO_BITS'(1);
            end
        end
    end

endmodule

// File: doc/prefetch_block_queue.md
Name: prefetch_block_queue

Overview:
Consumer end of the prefetcher control interface. Accepts prefetch addresses and flush commands from the stride controller, issues block reads to memory, and buffers returned blocks in an in-order circular queue. Answers demand read lookups with hit/data, and reports almostFull and outstandingReqCnt back to the controller.

Parameters:
ADDR_BITS, 64, address width
DATA_BITS, 512, block data width
BLOCK_OFFSET_BITS, 6, low address bits ignored in tag compare and forced to 0 on memReqAddr
QUEUE_DEPTH, 16, entries; power of 2, at least 4
ALMOST_FULL_MARGIN, 2, almostFull asserts when occupancy >= QUEUE_DEPTH-ALMOST_FULL_MARGIN
TIMEOUT_CYCLES, 256, cycles an unconsumed READY head may live before eviction

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
prefetchedAddrValid  in  1  allocate request from controller
prefetchedAddr  in  ADDR_BITS  address to prefetch
flushN  in  1  active-low flush, sampled at clk
inAddrReqValid  in  1  demand read lookup valid
inAddrReq  in  ADDR_BITS  demand read address
addrReqHit  out  1  combinational: lookup matches head tag and head is READY
addrReqPending  out  1  combinational: lookup matches head tag, head not yet READY
hitDataValid  out  1  registered, one-cycle pulse
hitData  out  DATA_BITS  block for the hit of the previous cycle
prefetchDrop  out  1  registered pulse: allocate request refused (full or flush)
memReqValid  out  1  read request to memory
memReqAddr  out  ADDR_BITS  block-aligned request address
memReqReady  in  1  memory accepts request
memRspValid  in  1  in-order read response, always accepted
memRspData  in  DATA_BITS  response block
almostFull  out  1  registered occupancy threshold
outstandingReqCnt  out  $clog2(QUEUE_DEPTH)+2  accepted by memory, response not yet received, including drained requests

Behaviour:
- Reset: all entries EMPTY; pointers, counters and drainCnt at 0; every output 0. addrReqHit/addrReqPending are 0 because no entries exist.
- Entry state: EMPTY -> ALLOC -> ISSUED -> READY -> EMPTY. Four pointers: tail (alloc), issue, fill, head (consume).
- Allocate: prefetchedAddrValid, occupancy<QUEUE_DEPTH and flushN=1 -> entry at tail becomes ALLOC with tag prefetchedAddr[ADDR_BITS-1:BLOCK_OFFSET_BITS]; tail++.
  - If full or flushing: no allocation; prefetchDrop pulses the next cycle.
  - Full is evaluated on start-of-cycle occupancy, so a same-cycle pop does not make room.
- Issue: memReqValid/memReqAddr come from a holding register. The register loads from the ALLOC entry at issue when empty or when being accepted this cycle, so a new entry reaches memReqValid at the earliest one cycle after allocation.
  - Once asserted, memReqValid and memReqAddr stay stable until memReqReady.
  - Acceptance moves the entry to ISSUED and increments outstandingReqCnt.
- Response: memRspValid with drainCnt>0 -> data discarded and drainCnt decrements. Otherwise the fill entry becomes READY with the data and fill++. Every response decrements outstandingReqCnt.
- Lookup: tag match is against the head entry only.
  - Head READY: addrReqHit=1; head pops the same edge; hitData/hitDataValid appear the next cycle.
  - Head ALLOC or ISSUED: addrReqPending=1; no state change.
  - Miss: no action.
- Timeout: a counter runs while the head is READY. It clears on pop or head change. Reaching TIMEOUT_CYCLES evicts the head silently.
- Flush (flushN=0 at the edge) has priority over allocate, lookup-pop and timeout:
  - All entries become EMPTY and pointers reset.
  - drainCnt += requests accepted and not yet returned, plus the holding-register request if valid.
  - The holding-register request is not withdrawn. It stays valid until accepted, its entry link is cleared, and its response is drained.
  - A response arriving in the flush cycle is counted before the drainCnt update.
- almostFull is registered from next-cycle occupancy.
- Reset mid-operation: everything clears immediately; in-flight memory responses after reset are memory-side responsibility.

Decomposition:
- Package prefetcher_pkg holds:
  - entry state enum (EMPTY/ALLOC/ISSUED/READY)
  - ADDR_BITS and BLOCK_OFFSET_BITS defaults
  - a block-tag extraction function shared with the controller
- One natural sub-module: prefetch_issue_reg, a valid/ready holding register with a stable-until-accepted guarantee.

Test Plan:
- Alloc 0x1000, memReqReady=1, response D0 two cycles later, lookup 0x1008 -> memReqAddr=0x1000; addrReqHit=1; hitData=D0 one cycle after hit; occupancy back to 0.
- QUEUE_DEPTH=4: 5 back-to-back allocs, memReqReady=0 -> 4 ALLOC; 5th gives prefetchDrop=1; almostFull=1 after the 2nd alloc; memReqValid and memReqAddr=first address held stable.
- Lookup 0x2000 while head ISSUED -> addrReqPending=1, addrReqHit=0; after response, same lookup -> addrReqHit=1.
- 3 requests accepted, flushN=0 with none returned -> drainCnt=3, outstandingReqCnt=3; next 3 responses discarded, no READY entries; a new alloc after that fills correctly.
- Flush while memReqValid=1 and memReqReady=0 -> memReqValid stays 1 until accepted; its response is discarded.
- TIMEOUT_CYCLES=8: head READY with no lookup -> head evicted after 8 cycles; a lookup on cycle 7 still hits.
